// File: rtl/seven_seg_scan_ctrl.sv
// Scan controller for a 4-digit common-anode display sharing one BCD decoder.
// Handles refresh timing, ghost guard, leading-zero blanking and frame-synchronous value updates.
module seven_seg_scan_ctrl #(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        lz_en,
  output logic [3:0]  digit_out,
  output logic [3:0]  an,
  output logic        frame_done
);
  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  typedef enum logic {SHOW, GUARD} state_t;

  state_t      state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]  idx, idx_nxt;
  logic [15:0] shadow, active;
  logic        pending;
  logic        advance, boundary;
  logic [3:0]  blank;
  logic        zero_above;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= SHOW;
      cnt   <= '0;
      idx   <= 2'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + CW'(1);
    advance   = 1'b0;
    case (state)
      SHOW: if (cnt == SHOW_LAST) begin
        cnt_nxt = '0;
        if (BLANK_CYCLES == 0) advance = 1'b1;
        else                   state_nxt = GUARD;
      end
      GUARD: if (cnt == GUARD_LAST) begin
        cnt_nxt   = '0;
        advance   = 1'b1;
        state_nxt = SHOW;
      end
      default: state_nxt = SHOW;
    endcase
    idx_nxt = advance ? idx + 2'd1 : idx;
  end

  // Leaving digit 3 closes the frame; this is the only point the visible value may change.
  assign boundary   = advance && (idx == 2'd3);
  assign frame_done = boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else if (boundary) begin
      if (load)         active <= value_in;
      else if (pending) active <= shadow;
      pending <= 1'b0;
    end else if (load) begin
      shadow  <= value_in;
      pending <= 1'b1;
    end
  end

  // A digit is blank when it and every digit to its left are zero; digit 0 always shows.
  always_comb begin
    blank      = '0;
    zero_above = lz_en;
    for (int i = 3; i >= 1; i--) begin
      zero_above = zero_above && (active[4*i +: 4] == 4'd0);
      blank[i]   = zero_above;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an        <= 4'b1111;
      digit_out <= 4'd0;
    end else if (state == SHOW && !blank[idx]) begin
      an        <= ~(4'b0001 << idx);
      digit_out <= active[4*idx +: 4];
    end else begin
      an        <= 4'b1111;
      digit_out <= 4'd0;
    end
  end
endmodule
